// File: rtl/bsg_acm_ctrl_modal_pkg.sv
// Shared types for the modal Arnold's Cat Map controller: FSM states and the
// encrypt/decrypt mode, plus a small width helper.
package bsg_acm_pkg;

   typedef enum logic [1:0] {
      eWAIT   = 2'd0,
      eREDUCE = 2'd1,
      eRUN    = 2'd2,
      eDONE   = 2'd3
   } bsg_acm_state_e;

   typedef enum logic {
      eENCRYPT = 1'b0,
      eDECRYPT = 1'b1
   } bsg_acm_mode_e;

   function automatic int max_width(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bsg_acm_ctrl_modal_if.sv
// Ready-valid job channel, result channel and cell-array strobes of the cat-map
// controller. The controller takes the slave side.
interface bsg_acm_ctrl_modal_if #(
   parameter int game_len_width_p = 11,
   parameter int period_width_p   = 8
) ();

   logic                        en_i;
   logic [game_len_width_p-1:0] frames_i;
   logic                        mode_i;
   logic                        v_i;
   logic                        ready_o;
   logic                        abort_i;
   logic                        yumi_i;
   logic                        v_o;
   logic [period_width_p-1:0]   iters_o;
   logic                        update_o;
   logic                        en_o;

   modport master (
      output en_i, frames_i, mode_i, v_i, abort_i, yumi_i,
      input  ready_o, v_o, iters_o, update_o, en_o
   );

   modport slave (
      input  en_i, frames_i, mode_i, v_i, abort_i, yumi_i,
      output ready_o, v_o, iters_o, update_o, en_o
   );

endinterface

// File: rtl/bsg_acm_iter_calc.sv
// Combinational step of the modulo reduction: one compare/subtract against the
// period, and the iteration count once the remainder is below the period.
module bsg_acm_iter_calc
   import bsg_acm_pkg::*;
#(
   parameter int game_len_width_p = 11,
   parameter int period_width_p   = 8,
   parameter int period_p         = 192
) (
   input  logic [game_len_width_p-1:0] rem_i,
   input  bsg_acm_mode_e               mode_i,
   output logic                        ge_period_o,
   output logic [game_len_width_p-1:0] rem_minus_period_o,
   output logic [period_width_p-1:0]   count_o
);

   localparam int calc_width_lp = max_width(game_len_width_p, period_width_p);
   localparam logic [calc_width_lp-1:0] period_lp = calc_width_lp'(period_p);

   logic [calc_width_lp-1:0] rem_ext;
   logic [calc_width_lp-1:0] rem_diff;
   logic [calc_width_lp-1:0] undo_count;

   assign rem_ext            = calc_width_lp'(rem_i);
   assign ge_period_o        = (rem_ext >= period_lp);
   assign rem_diff           = rem_ext - period_lp;
   assign rem_minus_period_o = game_len_width_p'(rem_diff);
   assign undo_count         = period_lp - rem_ext;

   // Decrypt undoes the remainder by running forward to the next full period.
   always_comb begin
      count_o = '0;
      if (mode_i == eENCRYPT) begin
         count_o = period_width_p'(rem_ext);
      end else if (rem_ext != '0) begin
         count_o = period_width_p'(undo_count);
      end
   end

endmodule

// File: rtl/bsg_acm_ctrl_modal.sv
// Control FSM for the cat-map cell array: accepts a frame count and mode,
// reduces it modulo the map period, then issues exactly the needed iterations.
module bsg_acm_ctrl_modal
   import bsg_acm_pkg::*;
#(
   parameter int board_width_p     = 128,
   parameter int max_game_length_p = 1024,
   parameter int period_p          = 192
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   bsg_acm_ctrl_modal_if.slave   io
);

   localparam int game_len_width_lp = $clog2(max_game_length_p + 1);
   localparam int period_width_lp   = $clog2(period_p + 1);
   localparam logic [period_width_lp-1:0] cnt_one_lp = period_width_lp'(1);

   bsg_acm_state_e                state_q, state_d;
   bsg_acm_mode_e                 mode_q, mode_d;
   logic [game_len_width_lp-1:0]  rem_q, rem_d;
   logic [period_width_lp-1:0]    cnt_q, cnt_d;
   logic [period_width_lp-1:0]    iters_q, iters_d;

   logic                          ge_period;
   logic [game_len_width_lp-1:0]  rem_minus_period;
   logic [period_width_lp-1:0]    count;

   bsg_acm_iter_calc #(
      .game_len_width_p (game_len_width_lp),
      .period_width_p   (period_width_lp),
      .period_p         (period_p)
   ) iter_calc (
      .rem_i              (rem_q),
      .mode_i             (mode_q),
      .ge_period_o        (ge_period),
      .rem_minus_period_o (rem_minus_period),
      .count_o            (count)
   );

   // Abort outranks every transition outside WAIT; counters still follow en_i.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      iters_d = iters_q;
      unique case (state_q)
         eWAIT: begin
            if (io.v_i) begin
               rem_d   = io.frames_i;
               mode_d  = bsg_acm_mode_e'(io.mode_i);
               iters_d = '0;
               state_d = eREDUCE;
            end
         end
         eREDUCE: begin
            if (io.abort_i) begin
               state_d = eWAIT;
            end else if (ge_period) begin
               rem_d = rem_minus_period;
            end else if (count == '0) begin
               state_d = eDONE;
            end else begin
               cnt_d   = count;
               state_d = eRUN;
            end
         end
         eRUN: begin
            if (io.en_i) begin
               cnt_d   = cnt_q - cnt_one_lp;
               iters_d = iters_q + cnt_one_lp;
               if (cnt_q == cnt_one_lp) begin
                  state_d = eDONE;
               end
            end
            if (io.abort_i) begin
               state_d = eWAIT;
            end
         end
         eDONE: begin
            if (io.abort_i || io.yumi_i) begin
               state_d = eWAIT;
            end
         end
         default: state_d = eWAIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= eWAIT;
         mode_q  <= eENCRYPT;
         rem_q   <= '0;
         cnt_q   <= '0;
         iters_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         iters_q <= iters_d;
      end
   end

   assign io.ready_o  = (state_q == eWAIT);
   assign io.v_o      = (state_q == eDONE);
   assign io.update_o = (state_q == eWAIT) && io.v_i;
   assign io.en_o     = (state_q == eRUN) && io.en_i;
   assign io.iters_o  = iters_q;

`ifndef SYNTHESIS
   a_period_legal: assert property (@(posedge clk_i) (period_p >= 1) && (board_width_p > 0));
   a_ready_v_excl: assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(io.v_o && io.ready_o));
   a_en_only_run:  assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(io.en_o && (state_q != eRUN)));
`endif

endmodule

// File: tb/tb_bsg_acm_ctrl_modal.sv
// Randomized and directed bench for bsg_acm_ctrl_modal, compared against a
// modulo-arithmetic model of the job (latency, iteration count, handshakes).
module tb_bsg_acm_ctrl_modal;
   import bsg_acm_pkg::*;

   localparam int period_lp   = 192;
   localparam int max_len_lp  = 1024;
   localparam int gw_lp       = $clog2(max_len_lp + 1);
   localparam int pw_lp       = $clog2(period_lp + 1);
   localparam int budget_lp   = 5000;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bsg_acm_ctrl_modal_if #(.game_len_width_p(gw_lp), .period_width_p(pw_lp)) acm_if ();

   bsg_acm_ctrl_modal #(
      .board_width_p     (128),
      .max_game_length_p (max_len_lp),
      .period_p          (period_lp)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .io      (acm_if)
   );

   task automatic checkOutput(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_count(input int frames, input int mode);
      int r;
      r = frames % period_lp;
      if (mode == 0) return r;
      return (r == 0) ? 0 : period_lp - r;
   endfunction

   function automatic int model_reduce_cycles(input int frames);
      return frames / period_lp + 1;
   endfunction

   // Runs one job from WAIT; stall_pct is the chance of en_i=0 per cycle,
   // abort_after >= 0 aborts once that many en_o pulses have been seen.
   task automatic applyStimulus(input int frames, input int mode, input int stall_pct,
                                input int abort_after, input int hold_cycles);
      int exp_cnt, exp_lat, pulses, cycles, bad_en, bad_rdy, unstable;
      bit seen_v;
      exp_cnt = model_count(frames, mode);
      exp_lat = model_reduce_cycles(frames);
      pulses = 0; cycles = 0; bad_en = 0; bad_rdy = 0; unstable = 0; seen_v = 0;

      @(negedge clk);
      acm_if.frames_i = gw_lp'(frames);
      acm_if.mode_i   = mode[0];
      acm_if.v_i      = 1'b1;
      acm_if.abort_i  = 1'($urandom_range(1));
      acm_if.en_i     = 1'($urandom_range(1));
      #1;
      checkOutput("ready_in_wait", int'(acm_if.ready_o), 1);
      checkOutput("update_on_v", int'(acm_if.update_o), 1);

      for (int c = 0; c < budget_lp; c++) begin
         @(negedge clk);
         acm_if.v_i      = 1'b0;
         acm_if.frames_i = gw_lp'($urandom_range(max_len_lp));
         acm_if.mode_i   = 1'($urandom_range(1));
         acm_if.en_i     = ($urandom_range(99) >= stall_pct);
         acm_if.abort_i  = (abort_after >= 0) && (pulses == abort_after);
         #1;
         if (acm_if.v_o) begin
            seen_v = 1;
            break;
         end
         if (acm_if.en_o && !acm_if.en_i) bad_en++;
         if (acm_if.en_o) pulses++;
         if (acm_if.ready_o) bad_rdy++;
         cycles++;
         if (acm_if.abort_i) begin
            @(negedge clk);
            acm_if.abort_i = 1'b0;
            acm_if.en_i    = 1'b0;
            #1;
            checkOutput("abort_ready", int'(acm_if.ready_o), 1);
            checkOutput("abort_no_v", int'(acm_if.v_o), 0);
            checkOutput("abort_en_follow", bad_en, 0);
            return;
         end
      end
      acm_if.abort_i = 1'b0;
      if (!seen_v) begin
         checkOutput("timeout_v_o", 0, 1);
         return;
      end

      checkOutput("iters_o", int'(acm_if.iters_o), exp_cnt);
      checkOutput("en_pulses", pulses, exp_cnt);
      checkOutput("en_while_stalled", bad_en, 0);
      checkOutput("ready_while_busy", bad_rdy, 0);
      if (stall_pct == 0) checkOutput("job_latency", cycles, exp_lat + exp_cnt);

      for (int h = 0; h < hold_cycles; h++) begin
         @(negedge clk);
         acm_if.yumi_i = 1'b0;
         acm_if.v_i    = (h == 0);
         #1;
         if (h == 0) begin
            checkOutput("done_no_update", int'(acm_if.update_o), 0);
            checkOutput("done_not_ready", int'(acm_if.ready_o), 0);
         end
         if (!acm_if.v_o || (int'(acm_if.iters_o) != exp_cnt)) unstable++;
      end
      if (hold_cycles > 0) checkOutput("hold_stable", unstable, 0);

      @(negedge clk);
      acm_if.v_i    = 1'b0;
      acm_if.yumi_i = 1'b1;
      #1;
      checkOutput("v_before_yumi", int'(acm_if.v_o), 1);
      @(negedge clk);
      acm_if.yumi_i = 1'b0;
      #1;
      checkOutput("ready_after_yumi", int'(acm_if.ready_o), 1);
      checkOutput("v_after_yumi", int'(acm_if.v_o), 0);
   endtask

   task automatic reset_mid_run();
      int pulses;
      pulses = 0;
      @(negedge clk);
      acm_if.frames_i = gw_lp'(5);
      acm_if.mode_i   = 1'b1;
      acm_if.v_i      = 1'b1;
      acm_if.en_i     = 1'b1;
      for (int c = 0; c < 50 && pulses < 10; c++) begin
         @(negedge clk);
         acm_if.v_i = 1'b0;
         #1;
         if (acm_if.en_o) pulses++;
      end
      checkOutput("pre_reset_pulses", pulses, 10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst_run_ready", int'(acm_if.ready_o), 1);
      checkOutput("rst_run_v", int'(acm_if.v_o), 0);
      checkOutput("rst_run_en", int'(acm_if.en_o), 0);
      checkOutput("rst_run_update", int'(acm_if.update_o), 0);
      checkOutput("rst_run_iters", int'(acm_if.iters_o), 0);
   endtask

   initial begin
      reset          = 1'b1;
      acm_if.en_i    = 1'b1;
      acm_if.frames_i = '0;
      acm_if.mode_i  = 1'b0;
      acm_if.v_i     = 1'b0;
      acm_if.abort_i = 1'b1;
      acm_if.yumi_i  = 1'b1;
      repeat (3) @(negedge clk);
      reset          = 1'b0;
      acm_if.abort_i = 1'b0;
      acm_if.yumi_i  = 1'b0;
      #1;
      checkOutput("reset_ready", int'(acm_if.ready_o), 1);
      checkOutput("reset_v", int'(acm_if.v_o), 0);
      checkOutput("reset_en", int'(acm_if.en_o), 0);
      checkOutput("reset_update", int'(acm_if.update_o), 0);
      checkOutput("reset_iters", int'(acm_if.iters_o), 0);

      applyStimulus(5, 1, 0, -1, 0);
      applyStimulus(400, 0, 0, -1, 0);
      applyStimulus(384, 1, 0, -1, 0);
      applyStimulus(10, 0, 50, -1, 0);
      applyStimulus(100, 1, 0, 20, 0);
      applyStimulus(100, 1, 0, -1, 0);
      applyStimulus(7, 0, 0, -1, 50);
      applyStimulus(0, 0, 0, -1, 0);
      applyStimulus(0, 1, 0, -1, 0);
      applyStimulus(max_len_lp, 1, 0, -1, 0);
      applyStimulus(period_lp - 1, 1, 0, -1, 0);
      applyStimulus(period_lp, 0, 0, -1, 0);
      applyStimulus(period_lp + 1, 1, 0, -1, 0);
      reset_mid_run();
      applyStimulus(3, 0, 0, -1, 0);

      for (int j = 0; j < 20; j++) begin
         applyStimulus(int'($urandom_range(max_len_lp)), int'($urandom_range(1)),
                       ($urandom_range(1) == 1) ? int'($urandom_range(70)) : 0,
                       ($urandom_range(4) == 0) ? int'($urandom_range(5)) : -1,
                       int'($urandom_range(3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bsg_acm_ctrl_modal.md
Name: bsg_acm_ctrl_modal

Overview:
Next-generation control FSM for the Arnold's Cat Map cell array. It accepts a frame count plus an encrypt/decrypt mode and reduces the count modulo the map period, which is now an explicit parameter. It then drives the array for exactly the required number of iterations, honouring a stall enable and an abort. It sits between the input/output ready-valid channels and the cell array, replacing the single-mode decrypt controller.

Parameters:
board_width_p, 128, image side length in cells; documentation and assertion only.
max_game_length_p, 1024, largest frames_i value accepted.
period_p, 192, cat-map period for board_width_p (3*N/2 for N a power of two); must be >= 1 and <= 2**16-1.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
en_i  in  1  iteration enable; low stalls RUN without losing progress
frames_i  in  game_len_width_lp  frames applied (encrypt) or to undo (decrypt); game_len_width_lp = clog2(max_game_length_p+1)
mode_i  in  1  0 = encrypt, 1 = decrypt; sampled with frames_i
v_i  in  1  input valid
ready_o  out  1  input ready; high only in WAIT
abort_i  in  1  cancel current job
yumi_i  in  1  output consumed
v_o  out  1  result valid; high only in DONE
iters_o  out  period_width_lp  en_o pulses issued in the current job; period_width_lp = clog2(period_p+1)
update_o  out  1  load strobe to the cell array
en_o  out  1  single-iteration strobe to the cell array

Behaviour:
- States: WAIT, REDUCE, RUN, DONE. Reset puts the FSM in WAIT and clears rem_r, cnt_r and iters_r to 0. After reset: ready_o=1; v_o, update_o and en_o are 0; iters_o=0.
- WAIT: ready_o=1. update_o = v_i (combinational, same cycle as the handshake). On v_i&ready_o: rem_r<=frames_i, mode_r<=mode_i, iters_r<=0, next state REDUCE. abort_i is ignored in WAIT.
- REDUCE runs one subtraction per cycle.
  - If rem_r >= period_p: rem_r <= rem_r - period_p and stay in REDUCE.
  - Otherwise compute the iteration count: encrypt gives count = rem_r; decrypt gives count = 0 if rem_r==0, else period_p - rem_r.
  - count==0 goes to DONE. Otherwise cnt_r<=count and go to RUN.
  - Latency in REDUCE is floor(frames_i/period_p)+1 cycles.
- RUN: en_o = en_i.
  - Each cycle with en_i=1: cnt_r decrements and iters_r increments.
  - If cnt_r==1 and en_i=1, next state is DONE. Exactly count en_o pulses are issued.
  - en_i=0 holds cnt_r and iters_r; stalls of any length are legal.
- DONE: v_o=1 and iters_o is stable. On v_o&yumi_i, next state is WAIT. A new input is accepted no earlier than the cycle after yumi; there is no same-cycle turnaround.
- abort_i in REDUCE, RUN or DONE: next state WAIT, with priority over every other transition. en_o is still driven by en_i in the abort cycle if in RUN. iters_r keeps its value until the next accept.
- reset_i overrides abort_i and all handshakes in any state.
- Arithmetic:
  - rem_r is game_len_width_lp wide.
  - Comparison and subtraction are done at max(game_len_width_lp, period_width_lp) width, zero-extended.
  - cnt_r and iters_r are period_width_lp wide and never overflow, since count <= period_p-1.
- Assertions (simulation only): period_p >= 1; v_o and ready_o are never both high; en_o is never high outside RUN.

Decomposition:
- Package bsg_acm_pkg holds:
  - state enum bsg_acm_state_e {eWAIT, eREDUCE, eRUN, eDONE} (2 bits);
  - mode enum bsg_acm_mode_e {eENCRYPT=0, eDECRYPT=1}.
- One natural sub-module, bsg_acm_iter_calc. It is purely combinational: it takes rem, mode and period_p and produces ge_period, rem_minus_period and count.
- The FSM, counters and handshake logic stay in bsg_acm_ctrl_modal.

Test Plan:
- Decrypt, frames_i=5, period 192, en_i=1: REDUCE takes 1 cycle, then 187 consecutive en_o pulses, then v_o with iters_o=187. yumi returns the FSM to WAIT and ready_o=1 the next cycle.
- Encrypt, frames_i=400: REDUCE takes 3 cycles (400→208→16), then 16 en_o pulses and iters_o=16. Decrypt with frames_i=384: 0 iterations, so v_o is asserted after 3 REDUCE cycles with iters_o=0 and no en_o pulse.
- Stall: encrypt frames_i=10 with en_i toggled 1,0,0,1,... The total en_o count is 10, iters_o=10, and en_o is never high while en_i=0.
- Abort: decrypt frames_i=100, assert abort_i after 20 en_o pulses. The FSM is in WAIT next cycle with ready_o=1, and no v_o is asserted. The next job runs correctly from scratch.
- Handshake edges: hold v_o with yumi_i=0 for 50 cycles, so v_o and iters_o stay stable. Assert v_i during DONE: not accepted, update_o=0. Assert reset_i mid-RUN: all outputs return to their reset values on the next cycle.
